// File: rtl/mul_sched_if.sv
// Bundled request, multiplier and result signals of the two-pipe multiply scheduler.
// Every handshake is valid/ready: a beat transfers on a rising edge where both are high.
interface mul_sched_if #(
   parameter int TAG_W = 4
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_op0;
   logic [1:0]       req_op1;
   logic [31:0]      req_src1_0;
   logic [31:0]      req_src2_0;
   logic [31:0]      req_src1_1;
   logic [31:0]      req_src2_1;
   logic [TAG_W-1:0] req_tag0;
   logic [TAG_W-1:0] req_tag1;
   logic             flush;
   logic             mul_start;
   logic             mul_signed;
   logic [31:0]      mul_a;
   logic [31:0]      mul_b;
   logic             mul_done;
   logic [63:0]      mul_result;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_data;
   logic [TAG_W-1:0] res_tag;
   logic             res_pipe;

   modport slave (
      input  req_valid, req_op0, req_op1, req_src1_0, req_src2_0, req_src1_1, req_src2_1,
             req_tag0, req_tag1, flush, mul_done, mul_result, res_ready,
      output req_ready, mul_start, mul_signed, mul_a, mul_b, res_valid, res_data, res_tag,
             res_pipe
   );

   modport master (
      output req_valid, req_op0, req_op1, req_src1_0, req_src2_0, req_src1_1, req_src2_1,
             req_tag0, req_tag1, flush, mul_done, mul_result, res_ready,
      input  req_ready, mul_start, mul_signed, mul_a, mul_b, res_valid, res_data, res_tag,
             res_pipe
   );
endinterface

// File: rtl/mul_sched.sv
// Round-robin scheduler that feeds one shared multiplier from two issue pipes,
// one operation at a time, and returns the selected product word with its tag.
module mul_sched #(
   parameter int TAG_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   mul_sched_if.slave bus,
   output logic [1:0] state_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state_q;
   logic             rr_q;          // 1 = pipe1 wins when both pipes request
   logic             mul_start_q;
   logic             mul_signed_q;
   logic [31:0]      mul_a_q;
   logic [31:0]      mul_b_q;
   logic             res_hi_q;
   logic             res_valid_q;
   logic [31:0]      res_data_q;
   logic [TAG_W-1:0] res_tag_q;
   logic             res_pipe_q;

   logic [1:0]       grant;
   logic [1:0]       sel_op;
   logic [31:0]      sel_a;
   logic [31:0]      sel_b;
   logic [TAG_W-1:0] sel_tag;

   always_comb begin
      grant = 2'b00;
      if (!rst && state_q == IDLE && !bus.flush) begin
         case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
      sel_op  = grant[1] ? bus.req_op1    : bus.req_op0;
      sel_a   = grant[1] ? bus.req_src1_1 : bus.req_src1_0;
      sel_b   = grant[1] ? bus.req_src2_1 : bus.req_src2_0;
      sel_tag = grant[1] ? bus.req_tag1   : bus.req_tag0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_q         <= 1'b0;
         mul_start_q  <= 1'b0;
         mul_signed_q <= 1'b0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         res_hi_q     <= 1'b0;
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_tag_q    <= '0;
         res_pipe_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|grant) begin
                  state_q      <= ISSUE;
                  mul_start_q  <= 1'b1;
                  rr_q         <= grant[0];
                  mul_a_q      <= sel_a;
                  mul_b_q      <= sel_b;
                  // Only MULH.WU is unsigned; op 11 behaves as MUL.W.
                  mul_signed_q <= (sel_op != 2'b10);
                  res_hi_q     <= (sel_op == 2'b01) || (sel_op == 2'b10);
                  res_tag_q    <= sel_tag;
                  res_pipe_q   <= grant[1];
               end
            end
            ISSUE: begin
               mul_start_q <= 1'b0;
               state_q     <= bus.flush ? IDLE : WAIT;
            end
            WAIT: begin
               if (bus.flush) begin
                  state_q <= IDLE;
               end else if (bus.mul_done) begin
                  res_data_q  <= res_hi_q ? bus.mul_result[63:32] : bus.mul_result[31:0];
                  res_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               // A flush discards the result even if the consumer takes it this cycle.
               if (bus.flush || bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = grant;
   assign bus.mul_start  = mul_start_q;
   assign bus.mul_signed = mul_signed_q;
   assign bus.mul_a      = mul_a_q;
   assign bus.mul_b      = mul_b_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_data   = res_data_q;
   assign bus.res_tag    = res_tag_q;
   assign bus.res_pipe   = res_pipe_q;
   assign state_o        = state_q;
endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: vector table, random operations against an
// arithmetic reference, and hand-written flush/stall/reset sequences.
module tb_mul_sched;
   localparam logic [1:0] ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2, ST_RESP = 2'd3;

   typedef struct {
      int          p;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] exp_d;
      logic        exp_s;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [1:0]  state;
   int          n_checks;
   int          n_err;
   logic        start_d;
   logic [63:0] prod_q;

   mul_sched_if #(.TAG_W(4)) bus ();

   mul_sched #(.TAG_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state_o (state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // multiplier: mul_done and product one cycle after mul_start
   always @(negedge clk) begin
      logic signed [63:0] sa, sb;
      bus.mul_done = start_d;
      if (start_d) bus.mul_result = prod_q;
      start_d = bus.mul_start;
      if (bus.mul_start) begin
         sa = $signed(bus.mul_a);
         sb = $signed(bus.mul_b);
         prod_q = bus.mul_signed ? 64'(sa * sb) : (64'(bus.mul_a) * 64'(bus.mul_b));
      end
   end

   function automatic logic [31:0] ref_res(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      longint          sp;
      longint unsigned up;
      sp = longint'($signed(a)) * longint'($signed(b));
      up = 64'(a) * 64'(b);
      case (op)
         2'b01:   return sp[63:32];
         2'b10:   return up[63:32];
         default: return up[31:0];
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_pipe(input int p, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] tag);
      if (p == 0) begin
         bus.req_op0 = op; bus.req_src1_0 = a; bus.req_src2_0 = b; bus.req_tag0 = tag;
      end else begin
         bus.req_op1 = op; bus.req_src1_1 = a; bus.req_src2_1 = b; bus.req_tag1 = tag;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // one full operation with res_ready high, checking every cycle of the latency
   task automatic run_op(input int p, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] exp_d, input logic exp_s);
      @(negedge clk);
      bus.res_ready = 1'b1;
      drive_pipe(p, op, a, b, tag);
      bus.req_valid = (p == 0) ? 2'b01 : 2'b10;
      #1 chk("grant_onehot", bus.req_ready, (p == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      bus.req_valid = 2'b00;
      chk("issue_state", state, ST_ISSUE);
      chk("mul_start_t1", bus.mul_start, 1);
      chk("mul_signed", bus.mul_signed, exp_s);
      chk("mul_a", bus.mul_a, a);
      chk("mul_b", bus.mul_b, b);
      @(negedge clk);
      chk("wait_state", state, ST_WAIT);
      chk("mul_start_pulse", bus.mul_start, 0);
      chk("mul_a_hold", bus.mul_a, a);
      chk("res_valid_early", bus.res_valid, 0);
      @(negedge clk);
      chk("res_valid_t3", bus.res_valid, 1);
      chk("res_data", bus.res_data, exp_d);
      chk("res_tag", bus.res_tag, tag);
      chk("res_pipe", bus.res_pipe, p[0]);
      @(negedge clk);
      chk("res_valid_drop", bus.res_valid, 0);
      chk("back_idle", state, ST_IDLE);
   endtask

   task automatic wait_resp(input string name);
      for (int i = 0; i < 10 && !bus.res_valid; i++) @(negedge clk);
      chk(name, bus.res_valid, 1);
   endtask

   initial begin
      vec_t tbl[7];
      int   got, last, exp_p;

      n_checks = 0; n_err = 0; start_d = 1'b0; prod_q = '0;
      rst = 1'b1; bus.req_valid = 2'b11; bus.flush = 1'b0; bus.res_ready = 1'b0;
      bus.mul_done = 1'b0; bus.mul_result = '0;
      drive_pipe(0, 2'b00, 32'd1, 32'd1, 4'd1);
      drive_pipe(1, 2'b00, 32'd1, 32'd1, 4'd2);

      tbl[0] = '{0, 2'b00, 32'h00000007, 32'hFFFFFFFF, 4'd3,  32'hFFFFFFF9, 1'b1};
      tbl[1] = '{1, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9,  32'hFFFFFFFE, 1'b0};
      tbl[2] = '{1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd10, 32'h00000000, 1'b1};
      tbl[3] = '{0, 2'b11, 32'h00010000, 32'h00010000, 4'd4,  32'h00000000, 1'b1};
      tbl[4] = '{0, 2'b01, 32'h80000000, 32'h80000000, 4'd5,  32'h40000000, 1'b1};
      tbl[5] = '{1, 2'b10, 32'h80000000, 32'h00000002, 4'd6,  32'h00000001, 1'b0};
      tbl[6] = '{1, 2'b01, 32'h80000000, 32'h00000002, 4'd15, 32'hFFFFFFFF, 1'b1};

      // reset state, with both pipes requesting
      repeat (2) @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 2'b00);
      chk("rst_state", state, ST_IDLE);
      chk("rst_mul_start", bus.mul_start, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_data", bus.res_data, 0);
      chk("rst_res_tag", bus.res_tag, 0);
      chk("rst_res_pipe", bus.res_pipe, 0);
      chk("rst_mul_a", bus.mul_a, 0);
      chk("rst_mul_b", bus.mul_b, 0);
      chk("rst_mul_signed", bus.mul_signed, 0);
      rst = 1'b0; bus.req_valid = 2'b00;

      foreach (tbl[i]) run_op(tbl[i].p, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag,
                              tbl[i].exp_d, tbl[i].exp_s);

      for (int i = 0; i < 16; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         logic [3:0]  tag;
         int          p;
         op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
         tag = 4'($urandom_range(0, 15)); p = $urandom_range(0, 1);
         run_op(p, op, a, b, tag, ref_res(op, a, b), op != 2'b10);
      end

      // round-robin with both pipes valid continuously
      do_reset();
      drive_pipe(0, 2'b00, 32'd3, 32'd5, 4'd1);
      drive_pipe(1, 2'b00, 32'd6, 32'd7, 4'd2);
      bus.req_valid = 2'b11; bus.res_ready = 1'b1;
      got = 0; last = 0; exp_p = 0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         @(negedge clk);
         if (bus.res_valid) begin
            chk("rr_pipe", bus.res_pipe, exp_p[0]);
            chk("rr_data", bus.res_data, (exp_p == 0) ? 32'd15 : 32'd42);
            if (got > 0) chk("rr_spacing", cyc - last, 4);
            last = cyc; exp_p ^= 1; got++;
         end
      end
      chk("rr_count", got, 6);
      bus.req_valid = 2'b00;
      repeat (6) @(negedge clk);

      // consumer stall for several cycles in RESP
      drive_pipe(0, 2'b00, 32'd9, 32'd9, 4'd5);
      bus.req_valid = 2'b01; bus.res_ready = 1'b0;
      @(negedge clk);
      wait_resp("stall_reach_resp");
      bus.req_valid = 2'b11;
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", bus.res_valid, 1);
         chk("stall_data", bus.res_data, 32'd81);
         chk("stall_tag", bus.res_tag, 5);
         chk("stall_req_ready", bus.req_ready, 2'b00);
      end
      bus.res_ready = 1'b1; bus.req_valid = 2'b00;
      @(negedge clk);
      chk("stall_release", bus.res_valid, 0);
      chk("stall_idle", state, ST_IDLE);

      // flush in WAIT coinciding with mul_done
      @(negedge clk);
      drive_pipe(1, 2'b00, 32'd2, 32'd3, 4'd7);
      bus.req_valid = 2'b10;
      @(negedge clk);
      bus.req_valid = 2'b00;
      @(negedge clk);
      chk("fw_in_wait", state, ST_WAIT);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("fw_idle", state, ST_IDLE);
      repeat (3) begin
         @(negedge clk);
         chk("fw_no_result", bus.res_valid, 0);
      end
      run_op(1, 2'b00, 32'd2, 32'd3, 4'd7, 32'd6, 1'b1);

      // flush in ISSUE still pulses mul_start; the late mul_done is ignored in IDLE
      @(negedge clk);
      drive_pipe(0, 2'b10, 32'd4, 32'd4, 4'd1);
      bus.req_valid = 2'b01;
      @(negedge clk);
      bus.req_valid = 2'b00; bus.flush = 1'b1;
      chk("fi_mul_start", bus.mul_start, 1);
      @(negedge clk);
      bus.flush = 1'b0;
      chk("fi_idle", state, ST_IDLE);
      chk("fi_start_low", bus.mul_start, 0);
      @(negedge clk);
      @(negedge clk);
      chk("fi_done_ignored", state, ST_IDLE);
      chk("fi_no_result", bus.res_valid, 0);

      // flush in IDLE blocks acceptance
      bus.req_valid = 2'b01; bus.flush = 1'b1;
      #1 chk("fidle_no_grant", bus.req_ready, 2'b00);
      @(negedge clk);
      chk("fidle_still_idle", state, ST_IDLE);
      bus.req_valid = 2'b00; bus.flush = 1'b0;

      // flush together with res_ready in RESP discards the result
      drive_pipe(1, 2'b01, 32'd5, 32'd5, 4'd2);
      bus.req_valid = 2'b10; bus.res_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_resp("fr_reach_resp");
      bus.flush = 1'b1; bus.res_ready = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("fr_valid_drop", bus.res_valid, 0);
      chk("fr_idle", state, ST_IDLE);

      // reset in RESP, then first grant goes to pipe0
      drive_pipe(1, 2'b00, 32'd11, 32'd13, 4'd12);
      bus.req_valid = 2'b10; bus.res_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_resp("rr_reach_resp");
      rst = 1'b1; bus.req_valid = 2'b11;
      @(negedge clk);
      chk("rstresp_valid", bus.res_valid, 0);
      chk("rstresp_state", state, ST_IDLE);
      chk("rstresp_data", bus.res_data, 0);
      chk("rstresp_pipe", bus.res_pipe, 0);
      chk("rstresp_req_ready", bus.req_ready, 2'b00);
      rst = 1'b0;
      #1 chk("rst_first_grant", bus.req_ready, 2'b01);
      @(negedge clk);
      bus.req_valid = 2'b00; bus.res_ready = 1'b1;
      chk("rst_grant_pipe", bus.res_pipe, 0);
      repeat (6) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
